adder_pipe_rc: RTL and testbench



---
 rtl/adder_pipe_rc.sv | 114 +++++++++++
 tb/tb_adder_pipe_rc.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_rc.sv
// adder_pipe_rc: pipelined ripple-carry adder with a valid/ready stream interface.
//
// The WIDTH-bit carry chain is cut into STAGES segments of SEG bits. Each
// stage adds one segment plus the carry registered by the stage before it.
// Each stage also carries forward the lower sum bits already computed and the
// operand bits not yet consumed. The last stage additionally registers the
// signed-overflow flag.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand beat handshake (in_ready = out_ready | ~out_valid)
//   in1, in2, cin       operands and carry in
//   out_valid/out_ready result handshake; outputs freeze while out_valid & ~out_ready
//   sum, cout, ovf      (in1+in2+cin) mod 2^WIDTH, carry out, two's-complement overflow
//
// Latency is STAGES cycles and throughput is 1 beat/cycle. A stall freezes the
// whole pipe.

module adder_pipe_rc #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SEG = WIDTH / STAGES;

    generate
        if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("adder_pipe_rc: WIDTH must be >= 2 and divisible by STAGES (1..WIDTH)");
        end
    endgenerate

    // Stage registers. Index k holds the state after stage k.
    logic [STAGES-1:0]            vld_pipe_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [STAGES-1:0]            c_q;
    logic                         ovf_q;

    // Stage inputs. Index 0 comes from the ports; index k+1 is the output of stage k.
    logic [STAGES:0]              v_p;
    logic [STAGES:0][WIDTH-1:0]   a_p, b_p, s_p;
    logic [STAGES:0]              c_p;

    logic                         advance;
    logic [STAGES-1:0][WIDTH-1:0] s_d;
    logic [STAGES-1:0]            c_d;
    logic                         ovf_d;
    logic [SEG:0]                 seg_sum;

    // Global stall: nothing moves while a result waits on the consumer.
    assign advance  = out_ready | ~vld_pipe_q[STAGES-1];
    assign in_ready = advance;

    assign v_p = {vld_pipe_q, in_valid & advance};
    assign a_p = {a_q, in1};
    assign b_p = {b_q, in2};
    assign s_p = {s_q, {WIDTH{1'b0}}};
    assign c_p = {c_q, cin};

    always_comb begin
        s_d     = '0;
        c_d     = '0;
        seg_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg_sum = {1'b0, a_p[k][k*SEG +: SEG]} + {1'b0, b_p[k][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, c_p[k]};
            s_d[k]                = s_p[k];
            s_d[k][k*SEG +: SEG]  = seg_sum[SEG-1:0];
            c_d[k]                = seg_sum[SEG];
        end
        // The carry into the MSB is a^b^sum at that bit; ovf is that XOR the carry out.
        ovf_d = a_p[STAGES-1][WIDTH-1] ^ b_p[STAGES-1][WIDTH-1]
              ^ s_d[STAGES-1][WIDTH-1] ^ c_d[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            s_q        <= '0;
            c_q        <= '0;
            ovf_q      <= 1'b0;
        end else if (advance) begin
            vld_pipe_q <= v_p[STAGES-1:0];
            a_q        <= a_p[STAGES-1:0];
            b_q        <= b_p[STAGES-1:0];
            s_q        <= s_d;
            c_q        <= c_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid = v_p[STAGES];
    assign sum       = s_p[STAGES];
    assign cout      = c_p[STAGES];
    assign ovf       = ovf_q;

    // All operand bits have been consumed by the time they reach the last register.
    logic unused_operands;
    assign unused_operands = ^{a_p[STAGES], b_p[STAGES]};

endmodule

// File: tb/tb_adder_pipe_rc.sv
module tb_adder_pipe_rc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  typedef struct {logic [63:0] s; logic c; logic o; int t; int sc;} e64_t;
  typedef struct {logic [7:0] s; logic c; logic o; int t; int sc;} e8_t;

  // ---------------- 64-bit, 4-stage instance ----------------
  logic        rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [63:0] in1, in2, sum;

  adder_pipe_rc #(.WIDTH(64), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  e64_t q64[$];
  int   sc64 = 0;

  // Reference: unsigned sum with a 65-bit accumulator; signed overflow from operand/result signs.
  function automatic e64_t model64(input logic [63:0] x, input logic [63:0] y, input logic ci);
    logic [64:0] full;
    e64_t e;
    full = {1'b0, x} + {1'b0, y} + {64'd0, ci};
    e.s  = full[63:0];
    e.c  = full[64];
    e.o  = (x[63] == y[63]) && (e.s[63] != x[63]);
    e.t  = cyc;
    e.sc = sc64;
    return e;
  endfunction

  task automatic send64(input logic [63:0] x, input logic [63:0] y, input logic ci);
    bit acc = 0;
    in_valid = 1'b1; in1 = x; in2 = y; cin = ci;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1; q64.push_back(model64(x, y, ci)); end
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send64_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain64();
    for (int n = 0; n < 200 && q64.size() != 0; n++) @(negedge clk);
    checks++;
    if (q64.size() != 0) begin
      errors++;
      $display("FAIL drain64 pending=%0d required 0", q64.size());
    end
    @(posedge clk); #1;
  endtask

  logic        p_stall = 1'b0;
  logic [63:0] p_sum;
  logic        p_c, p_o;

  always @(negedge clk) begin
    if (!rst_n) p_stall = 1'b0;
    else begin
      if (p_stall) begin
        checks++;
        if (!(out_valid && sum === p_sum && cout === p_c && ovf === p_o)) begin
          errors++;
          $display("FAIL hold64 got v=%b %h/%b/%b required v=1 %h/%b/%b",
                   out_valid, sum, cout, ovf, p_sum, p_c, p_o);
        end
      end
      if (out_valid && !out_ready) begin
        sc64++;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready64 got %b required 0", in_ready);
        end
        p_stall = 1'b1; p_sum = sum; p_c = cout; p_o = ovf;
      end else p_stall = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        if (q64.size() == 0) begin
          errors++;
          $display("FAIL unexpected64 got sum=%h required no output", sum);
        end else begin
          e64_t e;
          e = q64.pop_front();
          if (sum !== e.s || cout !== e.c || ovf !== e.o) begin
            errors++;
            $display("FAIL result64 got %h/%b/%b required %h/%b/%b", sum, cout, ovf, e.s, e.c, e.o);
          end
          checks++;
          if (cyc - e.t != 4 + (sc64 - e.sc)) begin
            errors++;
            $display("FAIL latency64 got %0d required %0d", cyc - e.t, 4 + (sc64 - e.sc));
          end
        end
      end
    end
  end

  // ---------------- 8-bit instances, STAGES = 1, 2, 8 ----------------
  logic rst8_n;
  logic start8 = 1'b0;
  int   done8  = 0;

  for (genvar g = 0; g < 3; g++) begin : g8
    localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    logic       iv, ir, ci, ov, ordy, co, of;
    logic [7:0] x, y, s;
    e8_t        q[$];
    int         sc = 0;
    logic       pst = 1'b0;
    logic [7:0] ps;
    logic       pc, po;

    adder_pipe_rc #(.WIDTH(8), .STAGES(S)) dut8 (
      .clk(clk), .rst_n(rst8_n), .in_valid(iv), .in_ready(ir),
      .in1(x), .in2(y), .cin(ci), .out_valid(ov), .out_ready(ordy),
      .sum(s), .cout(co), .ovf(of));

    // Reference: plain integer arithmetic, signed range check for overflow.
    function automatic e8_t model8(input logic [7:0] a, input logic [7:0] b, input logic c);
      int u, sa, sb, r;
      e8_t e;
      u  = int'(a) + int'(b) + int'(c);
      sa = (a > 8'd127) ? int'(a) - 256 : int'(a);
      sb = (b > 8'd127) ? int'(b) - 256 : int'(b);
      r  = sa + sb + int'(c);
      e.s  = u[7:0];
      e.c  = (u > 255);
      e.o  = (r > 127) || (r < -128);
      e.t  = cyc;
      e.sc = sc;
      return e;
    endfunction

    always @(posedge clk) begin
      #1;
      ordy = start8 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    initial begin
      logic [7:0] cv [5];
      bit acc;
      cv = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
      iv = 1'b0; x = '0; y = '0; ci = 1'b0;
      wait (start8);
      @(posedge clk); #1;
      for (int i = 0; i < 3050; i++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        if (i < 50) begin
          x = cv[i/10]; y = cv[(i/2)%5]; ci = 1'(i % 2);
        end else begin
          x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
        end
        iv  = 1'b1;
        acc = 0;
        for (int n = 0; n < 100 && !acc; n++) begin
          @(negedge clk);
          if (ir) begin acc = 1; q.push_back(model8(x, y, ci)); end
        end
        if (!acc) begin
          checks++; errors++;
          $display("FAIL send8_s%0d_timeout in_ready=%b required 1", S, ir);
        end
        @(posedge clk); #1;
        iv = 1'b0;
      end
      for (int n = 0; n < 500 && q.size() != 0; n++) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain8_s%0d pending=%0d required 0", S, q.size());
      end
      done8++;
    end

    always @(negedge clk) begin
      if (start8) begin
        if (pst) begin
          checks++;
          if (!(ov && s === ps && co === pc && of === po)) begin
            errors++;
            $display("FAIL hold8_s%0d got v=%b %h/%b/%b required v=1 %h/%b/%b", S, ov, s, co, of, ps, pc, po);
          end
        end
        if (ov && !ordy) begin
          sc++;
          pst = 1'b1; ps = s; pc = co; po = of;
        end else pst = 1'b0;
        if (ov && ordy) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected8_s%0d got sum=%h required no output", S, s);
          end else begin
            e8_t e;
            e = q.pop_front();
            if (s !== e.s || co !== e.c || of !== e.o) begin
              errors++;
              $display("FAIL result8_s%0d got %h/%b/%b required %h/%b/%b", S, s, co, of, e.s, e.c, e.o);
            end
            checks++;
            if (cyc - e.t != S + (sc - e.sc)) begin
              errors++;
              $display("FAIL latency8_s%0d got %0d required %0d", S, cyc - e.t, S + (sc - e.sc));
            end
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  bit rnd_or = 0;
  always @(posedge clk) begin
    #1;
    if (rnd_or) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    rst_n = 1'b0; rst8_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in1 = '0; in2 = '0; cin = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || sum !== 64'd0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b %h/%b/%b required v=0 0/0/0", out_valid, sum, cout, ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; rst8_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    start8 = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Carry ripples through every segment.
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    drain64();
    // Back-to-back beats.
    send64(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
    send64(64'h4011_29BC_3F98_ACE0, 64'hBA22_10AA_F486_76BC, 1'b0);
    drain64();
    // Signed overflow boundaries.
    send64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    send64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    drain64();

    // Back-pressure: out_ready dropped for 3 cycles as the first result appears.
    fork
      for (int i = 1; i <= 6; i++) send64(64'(i), 64'(i), 1'b0);
      begin
        bit seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(posedge clk); #1;
          if (out_valid) seen = 1;
        end
        if (seen) begin
          out_ready = 1'b0;
          repeat (3) @(posedge clk);
          #1 out_ready = 1'b1;
        end else begin
          checks++; errors++;
          $display("FAIL bp_first_result out_valid=%b required 1", out_valid);
        end
      end
    join
    drain64();

    // Asynchronous reset with beats in flight and a valid result at the output.
    for (int i = 0; i < 4; i++) send64(64'h1111_0000_0000_0000 * 64'(i + 1), 64'h0123_4567_89AB_CDEF, 1'b1);
    #2 rst_n = 1'b0;
    q64.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 64'd0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b %h/%b/%b required v=0 0/0/0", out_valid, sum, cout, ovf);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    send64(64'd1, 64'd1, 1'b1);
    drain64();

    // Random traffic with random back-pressure.
    rnd_or = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      case ($urandom_range(0, 3))
        0:       send64({32'hFFFF_FFFF, $urandom}, {$urandom, $urandom}, 1'($urandom));
        1:       send64({1'b0, 63'($urandom)}, {1'b0, 63'($urandom)}, 1'b1);
        default: send64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      endcase
    end
    rnd_or = 0;
    out_ready = 1'b1;
    drain64();

    for (int n = 0; n < 30000 && done8 < 3; n++) @(posedge clk);
    checks++;
    if (done8 != 3) begin
      errors++;
      $display("FAIL sweep8_done got %0d required 3", done8);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
